// File: rtl/mux_sel_arbiter8_if.sv
// mux_sel_arbiter8_if: request/grant bundle between requesters and the mux-select arbiter; lock exists only with ARB_LOCK_EN
interface mux_sel_arbiter8_if;
    logic [7:0] req;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
`ifdef ARB_LOCK_EN
    modport master (output req, output lock, input gnt, input sel, input busy);
    modport slave  (input req, input lock, output gnt, output sel, output busy);
`else
    modport master (output req, input gnt, input sel, input busy);
    modport slave  (input req, output gnt, output sel, output busy);
`endif
endinterface

// File: rtl/mux_sel_arbiter8.sv
// mux_sel_arbiter8: round-robin 8:1 select arbiter with hold timer and one turnaround cycle; ARB_LOCK_EN adds lock
module mux_sel_arbiter8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input logic               clk,
    input logic               rst_n,
    mux_sel_arbiter8_if.slave bus
);
    if (MAX_HOLD < 1 || MAX_HOLD > 2**CNT_W) begin : g_chk
        $error("mux_sel_arbiter8: illegal MAX_HOLD %0d for CNT_W %0d", MAX_HOLD, CNT_W);
    end
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n, sel, sel_n, win, idx;
    logic [7:0]       gnt, gnt_n;
    logic             busy, busy_n, found, lk, timeout, rel;
    logic [CNT_W-1:0] hold_cnt, cnt_n;
`ifdef ARB_LOCK_EN
    assign lk = bus.lock;
`else
    assign lk = 1'b0;
`endif
    assign timeout  = hold_cnt == CNT_W'(MAX_HOLD - 1);
    assign rel      = !bus.req[sel] || (timeout && !lk);
    assign bus.gnt  = gnt;
    assign bus.sel  = sel;
    assign bus.busy = busy;
    // first set request after ptr, wrapping; ptr itself is checked last
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && bus.req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = hold_cnt;
        gnt_n = gnt;
        sel_n = sel;
        busy_n = busy;
        case (state)
            OWN: begin
                if (rel) begin
                    state_n = TURN;
                    gnt_n = '0;
                    busy_n = 1'b0;
                    ptr_n = sel;
                end else begin
                    cnt_n = timeout ? hold_cnt : hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = found ? OWN : IDLE;
                gnt_n = found ? 8'b1 << win : '0;
                sel_n = found ? win : sel;
                busy_n = found;
                cnt_n = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= 3'd7;
            hold_cnt <= '0;
            gnt <= '0;
            sel <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            hold_cnt <= cnt_n;
            gnt <= gnt_n;
            sel <= sel_n;
            busy <= busy_n;
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter8.sv
// tb_mux_sel_arbiter8: vector table, hand sequences and randomized traffic against an ownership model
module tb_mux_sel_arbiter8;
    localparam int MH = 4;
    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int errors = 0;
    int owner = -1, held = 0, rr = 7, msel = 0;
    vec_t tbl[$];
    mux_sel_arbiter8_if bus();
    mux_sel_arbiter8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // owner/held/rr model; the dead cycle falls out of release clearing the owner
    task automatic model(input logic r, input logic [7:0] rq, input logic lk);
        if (!r) begin
            owner = -1;
            held = 0;
            rr = 7;
            msel = 0;
        end else if (owner >= 0) begin
            if (!rq[owner] || (held >= MH && !lk)) begin
                rr = owner;
                owner = -1;
            end else begin
                held++;
            end
        end else if (rq != 0) begin
            for (int k = 1; k <= 8; k++)
                if (rq[(rr + k) % 8]) begin
                    owner = (rr + k) % 8;
                    break;
                end
            held = 1;
            msel = owner;
        end
    endtask
    task automatic step(input logic r, input logic [7:0] rq, input logic lk);
        rst_n = r;
        bus.req = rq;
`ifdef ARB_LOCK_EN
        bus.lock = lk;
        model(r, rq, lk);
`else
        model(r, rq, 1'b0);
`endif
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es, input logic eb);
        vectors++;
        if (bus.gnt !== eg || bus.sel !== es || bus.busy !== eb) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b, expected gnt=%h sel=%0d busy=%b",
                     name, bus.gnt, bus.sel, bus.busy, eg, es, eb);
        end
    endtask
    task automatic check_model(input string name);
        check(name, owner >= 0 ? 8'(1 << owner) : 8'h00, 3'(msel), owner >= 0);
    endtask
    task automatic add(input int n, input logic r, input logic [7:0] rq, input logic [7:0] g,
                       input logic [2:0] s, input logic b);
        for (int i = 0; i < n; i++) tbl.push_back('{r, rq, g, s, b});
    endtask
    initial begin
        bus.req = '0;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        add(2, 0, 8'hFF, 8'h00, 0, 0);
        add(4, 1, 8'h08, 8'h08, 3, 1); add(1, 1, 8'h08, 8'h00, 3, 0);
        add(4, 1, 8'h08, 8'h08, 3, 1); add(1, 1, 8'h08, 8'h00, 3, 0);
        add(2, 1, 8'h08, 8'h08, 3, 1);
        add(1, 0, 8'h81, 8'h00, 0, 0);
        add(4, 1, 8'h81, 8'h01, 0, 1); add(1, 1, 8'h81, 8'h00, 0, 0);
        add(4, 1, 8'h81, 8'h80, 7, 1); add(1, 1, 8'h81, 8'h00, 7, 0);
        add(4, 1, 8'h81, 8'h01, 0, 1); add(1, 1, 8'h81, 8'h00, 0, 0);
        add(4, 1, 8'h81, 8'h80, 7, 1);
        add(1, 0, 8'h04, 8'h00, 0, 0);
        add(1, 1, 8'h04, 8'h04, 2, 1); add(1, 1, 8'h06, 8'h04, 2, 1);
        add(1, 1, 8'h02, 8'h00, 2, 0); add(1, 1, 8'h06, 8'h02, 1, 1);
        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].req, 1'b0);
            check("vec", tbl[i].gnt, tbl[i].sel, tbl[i].busy);
        end
        step(1, 8'h20, 0); check("rel_owner1", 8'h00, 1, 0);
        step(1, 8'h20, 0); check("grant5", 8'h20, 5, 1);
        step(1, 8'h20, 0); check("hold5", 8'h20, 5, 1);
        step(0, 8'h20, 0); check("rst_mid_own", 8'h00, 0, 0);
        step(1, 8'hA1, 0); check("ptr_after_rst", 8'h01, 0, 1);
        step(0, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h20, 1);
`ifdef ARB_LOCK_EN
            check("lock_hold", 8'h20, 5, 1);
`else
            check("lock_ignored", (i % 5) != 4 ? 8'h20 : 8'h00, 5, (i % 5) != 4);
`endif
        end
        for (int i = 0; i < 400; i++) begin
            logic [7:0] rq;
            rq = 8'($urandom) & 8'($urandom) & 8'($urandom_range(0, 3) == 0 ? 8'h00 : 8'hFF);
            step($urandom_range(0, 39) != 0, rq, 1'($urandom));
            check_model("rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
